game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Top-level game-state sequencer that consumes the sticky player1_dead/player2_dead flags from the hazard controllers, plus door-reached flags.
- Sequences title → play → death animation → game-over/win → restart.
- Drives level_reset back to the hazard controllers, clearing their sticky dead flags, and drives freeze/overlay controls for the player and renderer blocks.
- Moore FSM clocked on Clk; frame timing is derived from the VGA vsync.

Parameters:
- DEATH_FRAMES, 60, frames spent in DYING before GAME_OVER (1..255).
- FLASH_PERIOD, 8, frames per flash_on half-period during DYING (1..255).
- RESTART_CYCLES, 4, Clk cycles level_reset is held in RESTART (1..15).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  VGA vsync, same Clk domain; a frame tick is its rising edge.
- player1_dead  in  1  sticky death flag, OR of hazard controllers.
- player2_dead  in  1  sticky death flag, OR of hazard controllers.
- player1_at_door  in  1  player1 overlaps its exit door (level).
- player2_at_door  in  1  player2 overlaps its exit door (level).
- key_start  in  1  start key held (level).
- key_restart  in  1  restart key held (level).
- level_reset  out  1  synchronous reset to hazard/player/door blocks.
- players_frozen  out  1  inhibit player motion.
- game_state  out  3  encoded state for overlay selection.
- dead_player  out  2  {p2,p1} latched cause of death.
- flash_on  out  1  death-flash overlay enable.

Behaviour:
- Async Reset (active-high) values: state=IDLE, level_reset=1, players_frozen=1, dead_player=0, flash_on=0, all counters 0, edge-detector history regs 0.
- Edge detection:
  - frame_tick = frame_clk & ~frame_clk_q.
  - start_pe and restart_pe are rising edges of the keys, each via a 1-flop history.
  - A key held through Reset release does not fire.
- All outputs are registered, Moore-decoded from the state register. An input sampled at edge n affects outputs after edge n (1-cycle latency).
- Encodings: IDLE=0, RESTART=1, PLAY=2, DYING=3, OVER=4, WIN=5.
- IDLE:
  - level_reset=1, frozen=1.
  - start_pe → RESTART. Dead/door inputs ignored.
- RESTART:
  - level_reset=1, frozen=1, dead_player cleared on entry.
  - rst_cnt counts Clk cycles; after RESTART_CYCLES cycles → PLAY. level_reset is high for exactly RESTART_CYCLES cycles.
  - All inputs ignored, including new key edges.
- PLAY (level_reset=0, frozen=0), priorities highest first:
  - Any dead → DYING, with dead_player <= {p2_dead, p1_dead}.
  - Else restart_pe → RESTART.
  - Else both at_door (same cycle) → WIN.
  - Death beats win when simultaneous. A single player at the door does nothing.
- DYING:
  - frozen=1.
  - dead_player |= {p2_dead, p1_dead} each cycle, so a late second death is added.
  - frame_cnt increments per frame_tick. When frame_cnt==DEATH_FRAMES-1 and frame_tick → OVER.
  - flash_on starts 1 on entry and toggles every FLASH_PERIOD frame_ticks.
  - Keys ignored.
- OVER / WIN:
  - frozen=1, flash_on=0, dead_player held.
  - restart_pe → RESTART; start_pe ignored.
- flash_on=0 in every state except DYING.
- Counters:
  - frame_cnt is 8-bit and flash_cnt is 8-bit; both clear on any state change.
  - rst_cnt is 4-bit.
  - No wrap-around is reachable given the parameter ranges.
- Async Reset mid-operation returns to IDLE immediately, regardless of state or counters.

Decomposition:
- Package game_pkg:
  - typedef enum logic [2:0] game_state_t {IDLE, RESTART, PLAY, DYING, OVER, WIN} with the encodings above.
  - Default parameter constants.
- Sub-module rise_edge (Clk, Reset, in → pulse), instantiated 3× for frame_clk, key_start and key_restart.
- FSM and counters stay in game_flow_controller.

Test Plan (DEATH_FRAMES=4, FLASH_PERIOD=2, RESTART_CYCLES=3, frame_clk pulsed every 20 Clk):
- Reset, then key_start high → 1 cycle later RESTART, level_reset=1 for exactly 3 cycles, then PLAY with game_state=2, frozen=0.
- In PLAY, player2_dead=1 → next cycle DYING, dead_player=2'b10. flash_on pattern per frame is 1,1,0,0. After 4th frame_tick → OVER (4), flash_on=0.
- In DYING, player1_dead rises after 2 frames → dead_player=2'b11; the DYING-to-OVER exit frame is unchanged.
- In PLAY, both at_door=1 and player1_dead=1 in the same cycle → DYING, not WIN. With both at_door and no death → WIN (5).
- In OVER, key_restart held from before → no action. Release then press → RESTART → PLAY, and dead_player=0.
- Assert Reset mid-DYING → state IDLE, level_reset=1, flash_on=0 before the next Clk edge. key_start held across Reset deassert → stays IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game flow controller.
// State encodings are visible on game_state and drive overlay selection.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTART = 3'd1,
        PLAY    = 3'd2,
        DYING   = 3'd3,
        OVER    = 3'd4,
        WIN     = 3'd5
    } game_state_t;

    localparam int DEATH_FRAMES_DEF   = 60;
    localparam int FLASH_PERIOD_DEF   = 8;
    localparam int RESTART_CYCLES_DEF = 4;

endpackage

// File: rtl/rise_edge.sv
// Single-flop rising-edge detector. The armed flop suppresses a pulse for a
// level that is already high when reset releases.
module rise_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic in,
    output logic pulse
);

    logic hist_q;
    logic armed_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= in;
            armed_q <= 1'b1;
        end
    end

    assign pulse = in & ~hist_q & armed_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game-state sequencer: title, restart, play, death animation, over/win.
// Outputs are registered from the next state so inputs act with one cycle of latency.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int DEATH_FRAMES   = DEATH_FRAMES_DEF,
    parameter int FLASH_PERIOD   = FLASH_PERIOD_DEF,
    parameter int RESTART_CYCLES = RESTART_CYCLES_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       player1_dead,
    input  logic       player2_dead,
    input  logic       player1_at_door,
    input  logic       player2_at_door,
    input  logic       key_start,
    input  logic       key_restart,
    output logic       level_reset,
    output logic       players_frozen,
    output logic [2:0] game_state,
    output logic [1:0] dead_player,
    output logic       flash_on
);

    logic frame_tick;
    logic start_pe;
    logic restart_pe;

    rise_edge u_frame_edge   (.Clk(Clk), .Reset(Reset), .in(frame_clk),   .pulse(frame_tick));
    rise_edge u_start_edge   (.Clk(Clk), .Reset(Reset), .in(key_start),   .pulse(start_pe));
    rise_edge u_restart_edge (.Clk(Clk), .Reset(Reset), .in(key_restart), .pulse(restart_pe));

    game_state_t state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [1:0]  dead_q, dead_d;
    logic        flash_q, flash_d;
    logic        level_reset_q;
    logic        frozen_q;

    logic [1:0]  deaths;
    assign deaths = {player2_dead, player1_dead};

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        flash_cnt_d = flash_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        dead_d      = dead_q;
        flash_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_pe) state_d = RESTART;
            end
            RESTART: begin
                if (rst_cnt_q == 4'(RESTART_CYCLES - 1)) state_d = PLAY;
                else                                      rst_cnt_d = rst_cnt_q + 4'd1;
            end
            PLAY: begin
                // Death outranks both a restart request and a simultaneous win.
                if (|deaths) begin
                    state_d = DYING;
                    dead_d  = deaths;
                end else if (restart_pe) begin
                    state_d = RESTART;
                end else if (player1_at_door && player2_at_door) begin
                    state_d = WIN;
                end
            end
            DYING: begin
                dead_d  = dead_q | deaths;
                flash_d = flash_q;
                if (frame_tick) begin
                    if (frame_cnt_q == 8'(DEATH_FRAMES - 1)) state_d = OVER;
                    else                                      frame_cnt_d = frame_cnt_q + 8'd1;
                    if (flash_cnt_q == 8'(FLASH_PERIOD - 1)) begin
                        flash_d     = ~flash_q;
                        flash_cnt_d = 8'd0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                end
            end
            OVER, WIN: begin
                if (restart_pe) state_d = RESTART;
            end
            default: state_d = IDLE;
        endcase

        // Every state starts with fresh counters; the flash starts lit on entering DYING.
        if (state_d != state_q) begin
            frame_cnt_d = 8'd0;
            flash_cnt_d = 8'd0;
            rst_cnt_d   = 4'd0;
            flash_d     = (state_d == DYING);
        end
        if (state_d == RESTART && state_q != RESTART) dead_d = 2'b00;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            frame_cnt_q   <= 8'd0;
            flash_cnt_q   <= 8'd0;
            rst_cnt_q     <= 4'd0;
            dead_q        <= 2'b00;
            flash_q       <= 1'b0;
            level_reset_q <= 1'b1;
            frozen_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            dead_q        <= dead_d;
            flash_q       <= flash_d;
            level_reset_q <= (state_d == IDLE) || (state_d == RESTART);
            frozen_q      <= (state_d != PLAY);
        end
    end

    assign game_state     = state_q;
    assign level_reset    = level_reset_q;
    assign players_frozen = frozen_q;
    assign dead_player    = dead_q;
    assign flash_on       = flash_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scenario bench for game_flow_controller with a frame-level reference model
// and a randomized soak phase.
module tb_game_flow_controller;

    localparam int DF = 4;
    localparam int FP = 2;
    localparam int RC = 3;

    localparam int S_IDLE    = 0;
    localparam int S_RESTART = 1;
    localparam int S_PLAY    = 2;
    localparam int S_DYING   = 3;
    localparam int S_OVER    = 4;
    localparam int S_WIN     = 5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       player1_dead = 1'b0;
    logic       player2_dead = 1'b0;
    logic       player1_at_door = 1'b0;
    logic       player2_at_door = 1'b0;
    logic       key_start = 1'b0;
    logic       key_restart = 1'b0;
    logic       level_reset;
    logic       players_frozen;
    logic [2:0] game_state;
    logic [1:0] dead_player;
    logic       flash_on;

    game_flow_controller #(
        .DEATH_FRAMES  (DF),
        .FLASH_PERIOD  (FP),
        .RESTART_CYCLES(RC)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .player1_dead   (player1_dead),
        .player2_dead   (player2_dead),
        .player1_at_door(player1_at_door),
        .player2_at_door(player2_at_door),
        .key_start      (key_start),
        .key_restart    (key_restart),
        .level_reset    (level_reset),
        .players_frozen (players_frozen),
        .game_state     (game_state),
        .dead_player    (dead_player),
        .flash_on       (flash_on)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ticks = 0;

    // Reference model: mode, time spent in it, and latched deaths
    int         m_state;
    int         m_rst;
    int         m_frames;
    logic [1:0] m_dead;
    bit         m_armed, pv_start, pv_restart, pv_frame;

    task automatic model_reset();
        m_state = S_IDLE; m_rst = 0; m_frames = 0; m_dead = 2'b00;
        m_armed = 1'b0; pv_start = 1'b0; pv_restart = 1'b0; pv_frame = 1'b0;
    endtask

    task automatic model_update();
        bit sp, rp, fr;
        logic [1:0] d;
        sp = m_armed && key_start   && !pv_start;
        rp = m_armed && key_restart && !pv_restart;
        fr = m_armed && frame_clk   && !pv_frame;
        pv_start = key_start; pv_restart = key_restart; pv_frame = frame_clk; m_armed = 1'b1;
        d = {player2_dead, player1_dead};
        case (m_state)
            S_IDLE: if (sp) begin m_state = S_RESTART; m_rst = 0; m_dead = 2'b00; end
            S_RESTART: begin
                m_rst++;
                if (m_rst == RC) m_state = S_PLAY;
            end
            S_PLAY: begin
                if (d != 2'b00) begin m_state = S_DYING; m_dead = d; m_frames = 0; end
                else if (rp) begin m_state = S_RESTART; m_rst = 0; m_dead = 2'b00; end
                else if (player1_at_door && player2_at_door) m_state = S_WIN;
            end
            S_DYING: begin
                m_dead = m_dead | d;
                if (fr) begin
                    m_frames++;
                    if (m_frames == DF) m_state = S_OVER;
                end
            end
            default: if (rp) begin m_state = S_RESTART; m_rst = 0; m_dead = 2'b00; end
        endcase
    endtask

    function automatic logic [7:0] exp_vec();
        logic lr, fz, fl;
        lr = (m_state == S_IDLE) || (m_state == S_RESTART);
        fz = (m_state != S_PLAY);
        fl = (m_state == S_DYING) && (((m_frames / FP) % 2) == 0);
        return {lr, fz, 3'(m_state), m_dead, fl};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {level_reset, players_frozen, game_state, dead_player, flash_on};
    endfunction

    // One Clk cycle: frame_clk is high for 2 of every 20 cycles
    task automatic step();
        frame_clk = ((cyc % 20) < 2);
        if (cyc % 20 == 0) ticks++;
        cyc++;
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic run_until(input logic [2:0] target, input int max, output int n);
        n = -1;
        for (int i = 0; i < max; i++) begin
            if (game_state == target) begin n = i; break; end
            step();
        end
        if (n < 0 && game_state == target) n = max;
    endtask

    task automatic restart_to_play();
        int n;
        player1_dead = 1'b0; player2_dead = 1'b0;
        key_restart = 1'b0; step();
        key_restart = 1'b1; step();
        key_restart = 1'b0;
        run_until(3'd2, 20, n);
        total++;
        if (n < 0) begin bad++; $display("FAIL restart_to_play timeout state=%0d want=2", game_state); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        total++;
        if (dut_vec() !== 8'hC0) begin bad++; $display("FAIL reset_values got=%h want=c0", dut_vec()); end
        model_reset();
        Reset = 1'b0;
        repeat (3) step();
        total++;
        if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL idle_hold got=%h want=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_start();
        int lr_cycles;
        key_start = 1'b1; step();
        total++;
        if (game_state !== 3'd1 || level_reset !== 1'b1) begin
            bad++; $display("FAIL start_enter got=%0d/%b want=1/1", game_state, level_reset);
        end
        key_start = 1'b0;
        lr_cycles = 1;
        for (int i = 0; i < 10 && game_state == 3'd1; i++) begin
            step();
            if (game_state == 3'd1 && level_reset) lr_cycles++;
        end
        total++;
        if (lr_cycles != RC) begin bad++; $display("FAIL restart_len got=%0d want=%0d", lr_cycles, RC); end
        total++;
        if ({game_state, players_frozen, level_reset} !== {3'd2, 1'b0, 1'b0}) begin
            bad++; $display("FAIL play_enter got=%0d/%b/%b want=2/0/0", game_state, players_frozen, level_reset);
        end
        total++;
        if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL start_model got=%h want=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_dying();
        int t0, k;
        logic [3:0] pat;
        player2_dead = 1'b1; step();
        total++;
        if ({game_state, dead_player, flash_on} !== {3'd3, 2'b10, 1'b1}) begin
            bad++; $display("FAIL dying_enter got=%0d/%b/%b want=3/10/1", game_state, dead_player, flash_on);
        end
        t0 = ticks; pat = 4'b0000; pat[0] = flash_on;
        for (int i = 0; i < 200 && game_state == 3'd3; i++) begin
            step();
            k = ticks - t0;
            if (game_state == 3'd3 && k < 4) pat[k] = flash_on;
        end
        total++;
        if (pat !== 4'b0011) begin bad++; $display("FAIL flash_pattern got=%b want=0011", pat); end
        total++;
        if (game_state !== 3'd4 || flash_on !== 1'b0 || (ticks - t0) != DF) begin
            bad++; $display("FAIL over_enter got=%0d/%b ticks=%0d want=4/0 ticks=%0d", game_state, flash_on, ticks - t0, DF);
        end
        total++;
        if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL dying_model got=%h want=%h", dut_vec(), exp_vec()); end
        restart_to_play();
    endtask

    task automatic test_late_death_and_held_key();
        int t0;
        player2_dead = 1'b1; key_restart = 1'b1; step();
        total++;
        if (game_state !== 3'd3 || dead_player !== 2'b10) begin
            bad++; $display("FAIL late_enter got=%0d/%b want=3/10", game_state, dead_player);
        end
        t0 = ticks;
        for (int i = 0; i < 100 && (ticks - t0) < 2; i++) step();
        player1_dead = 1'b1; step();
        total++;
        if (game_state !== 3'd3 || dead_player !== 2'b11) begin
            bad++; $display("FAIL late_add got=%0d/%b want=3/11", game_state, dead_player);
        end
        for (int i = 0; i < 200 && game_state == 3'd3; i++) step();
        total++;
        if (game_state !== 3'd4 || (ticks - t0) != DF) begin
            bad++; $display("FAIL late_exit got=%0d ticks=%0d want=4 ticks=%0d", game_state, ticks - t0, DF);
        end
        repeat (5) step();
        total++;
        if (game_state !== 3'd4 || dead_player !== 2'b11) begin
            bad++; $display("FAIL held_key got=%0d/%b want=4/11", game_state, dead_player);
        end
        key_restart = 1'b0; step();
        key_restart = 1'b1; step();
        total++;
        if (game_state !== 3'd1 || dead_player !== 2'b00 || level_reset !== 1'b1) begin
            bad++; $display("FAIL over_restart got=%0d/%b/%b want=1/00/1", game_state, dead_player, level_reset);
        end
        player1_dead = 1'b0; player2_dead = 1'b0; key_restart = 1'b0;
        repeat (RC) step();
        total++;
        if (dut_vec() !== exp_vec() || game_state !== 3'd2) begin
            bad++; $display("FAIL back_to_play got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_death_beats_win();
        int n;
        player1_at_door = 1'b1; player2_at_door = 1'b1; player1_dead = 1'b1; step();
        total++;
        if (game_state !== 3'd3 || dead_player !== 2'b01) begin
            bad++; $display("FAIL death_vs_win got=%0d/%b want=3/01", game_state, dead_player);
        end
        player1_at_door = 1'b0; player2_at_door = 1'b0;
        run_until(3'd4, 200, n);
        total++;
        if (n < 0) begin bad++; $display("FAIL dbw_over timeout state=%0d want=4", game_state); end
        restart_to_play();
    endtask

    task automatic test_win();
        player1_at_door = 1'b1; step(); step();
        total++;
        if (game_state !== 3'd2) begin bad++; $display("FAIL single_door got=%0d want=2", game_state); end
        player2_at_door = 1'b1; step();
        total++;
        if ({game_state, players_frozen, flash_on, level_reset} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL win_enter got=%0d/%b/%b/%b want=5/1/0/0", game_state, players_frozen, flash_on, level_reset);
        end
        player1_at_door = 1'b0; player2_at_door = 1'b0;
        restart_to_play();
    endtask

    task automatic test_reset_mid_dying();
        player1_dead = 1'b1; step();
        repeat (5) step();
        total++;
        if (game_state !== 3'd3) begin bad++; $display("FAIL mid_pre got=%0d want=3", game_state); end
        #2 Reset = 1'b1;
        #1;
        total++;
        if ({game_state, level_reset, flash_on, players_frozen} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL async_reset got=%0d/%b/%b/%b want=0/1/0/1", game_state, level_reset, flash_on, players_frozen);
        end
        key_start = 1'b1; player1_dead = 1'b0;
        repeat (2) @(negedge Clk);
        model_reset();
        Reset = 1'b0;
        repeat (4) step();
        total++;
        if (game_state !== 3'd0 || level_reset !== 1'b1) begin
            bad++; $display("FAIL held_start got=%0d/%b want=0/1", game_state, level_reset);
        end
        key_start = 1'b0; step();
        key_start = 1'b1; step();
        total++;
        if (game_state !== 3'd1) begin bad++; $display("FAIL fresh_start got=%0d want=1", game_state); end
        key_start = 1'b0;
        repeat (RC) step();
        total++;
        if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL post_reset_model got=%h want=%h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) key_start   = ~key_start;
            if ($urandom_range(0, 5) == 0) key_restart = ~key_restart;
            player1_at_door = ($urandom_range(0, 2) == 0);
            player2_at_door = ($urandom_range(0, 2) == 0);
            player1_dead = level_reset ? 1'b0 : (player1_dead | ($urandom_range(0, 59) == 0));
            player2_dead = level_reset ? 1'b0 : (player2_dead | ($urandom_range(0, 59) == 0));
            step();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_dying();
        test_late_death_and_held_key();
        test_death_beats_win();
        test_win();
        test_reset_mid_dying();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t limit=2000000", $time);
        $fatal(1, "timeout");
    end

endmodule
